// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC six-step commutator.
//   - state_e    : commutator FSM state encoding
//   - HALL_*     : hall sensor code constants ({hall3,hall2,hall1})
//   - PH_*       : one-hot phase selects ({C,B,A})
//   - hall_valid : 1 for the six legal hall codes
//   - comm_sel   : hall code + direction -> {high[2:0], low[2:0]} phase select
package bldc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEADTIME = 2'd1,
      ST_RUN      = 2'd2,
      ST_FAULT    = 2'd3
   } state_e;

   localparam logic [2:0] HALL_000 = 3'b000;
   localparam logic [2:0] HALL_001 = 3'b001;
   localparam logic [2:0] HALL_010 = 3'b010;
   localparam logic [2:0] HALL_011 = 3'b011;
   localparam logic [2:0] HALL_100 = 3'b100;
   localparam logic [2:0] HALL_101 = 3'b101;
   localparam logic [2:0] HALL_110 = 3'b110;
   localparam logic [2:0] HALL_111 = 3'b111;

   localparam logic [2:0] PH_NONE = 3'b000;
   localparam logic [2:0] PH_A    = 3'b001;
   localparam logic [2:0] PH_B    = 3'b010;
   localparam logic [2:0] PH_C    = 3'b100;

   function automatic logic hall_valid(input logic [2:0] code);
      return (code != HALL_000) && (code != HALL_111);
   endfunction

   // Forward table gives (high, low); reverse swaps them. Invalid codes select nothing.
   function automatic logic [5:0] comm_sel(input logic [2:0] code, input logic rev);
      logic [2:0] hi;
      logic [2:0] lo;
      hi = PH_NONE;
      lo = PH_NONE;
      case (code)
         HALL_101: begin hi = PH_A; lo = PH_B; end
         HALL_100: begin hi = PH_A; lo = PH_C; end
         HALL_110: begin hi = PH_B; lo = PH_C; end
         HALL_010: begin hi = PH_B; lo = PH_A; end
         HALL_011: begin hi = PH_C; lo = PH_A; end
         HALL_001: begin hi = PH_C; lo = PH_B; end
         default:  begin hi = PH_NONE; lo = PH_NONE; end
      endcase
      return rev ? {lo, hi} : {hi, lo};
   endfunction

endpackage

// File: rtl/hall_debounce.sv
// Hall sensor synchronizer and debouncer.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   hall_i[2:0]      : raw asynchronous hall inputs
//   hall_state_o     : accepted (debounced) hall code
//   hall_error_o     : accepted code is 000 or 111
module hall_debounce
   import bldc_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 32
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic [2:0] hall_i,
   output logic [2:0] hall_state_o,
   output logic       hall_error_o
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [2:0]       sync1_q, sync1_d;
   logic [2:0]       sync2_q, sync2_d;
   logic [2:0]       cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       state_q, state_d;
   logic             err_q, err_d;

   // Registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         state_q <= '0;
         err_q   <= 1'b1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // A new candidate restarts the count; accept once it has been stable long enough
   always_comb begin
      sync1_d = hall_i;
      sync2_d = sync1_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      err_d   = err_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cand_q != state_q) begin
         if (cnt_q == CNT_LAST) begin
            state_d = cand_q;
            err_d   = !hall_valid(cand_q);
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   assign hall_state_o = state_q;
   assign hall_error_o = err_q;

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator with dead-time and fault handling.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   hall[2:0]           : raw hall sensors {hall3,hall2,hall1}
//   fault_n             : gate-driver fault (active-low, asynchronous)
//   enable, dir         : bridge enable, direction (0 = forward)
//   pwm_in              : PWM applied to the selected high-side gate
//   inh[2:0], inl[2:0]  : high/low-side gates {C,B,A}
//   hall_state          : debounced hall code; hall_error flags 000/111
//   fault               : FSM is in FAULT
//   period, period_valid: cycles between accepted valid hall transitions
// Optional feature: define BLDC_COMMUTATOR_PERIOD_EN to build the period
// measurement; otherwise period/period_valid are tied to 0.
module bldc_commutator
   import bldc_pkg::*;
#(
   parameter int unsigned DEADTIME_CYCLES = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 32,
   parameter int unsigned PERIOD_W        = 24
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [2:0]          hall,
   input  logic                fault_n,
   input  logic                enable,
   input  logic                dir,
   input  logic                pwm_in,
   output logic [2:0]          inh,
   output logic [2:0]          inl,
   output logic [2:0]          hall_state,
   output logic                hall_error,
   output logic                fault,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid
);

   localparam int unsigned DT_W = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
   localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYCLES - 1);

   state_e          state_q, state_d;
   logic [DT_W-1:0] dt_q, dt_d;
   logic [5:0]      sel_q, sel_d;
   logic [2:0]      inh_q, inh_d;
   logic [2:0]      inl_q, inl_d;
   logic            fault_q, fault_d;
   logic            fsync1_q, fsync2_q;
   logic [5:0]      cur_sel;

   hall_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_hall_debounce (
      .clk_i       (clk),
      .reset_n_i   (reset_n),
      .hall_i      (hall),
      .hall_state_o(hall_state),
      .hall_error_o(hall_error)
   );

   // Fault synchronizer resets to the inactive level so reset release is not a fault
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsync1_q <= 1'b1;
         fsync2_q <= 1'b1;
      end else begin
         fsync1_q <= fault_n;
         fsync2_q <= fsync1_q;
      end
   end

   // FSM and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         dt_q    <= '0;
         sel_q   <= '0;
         inh_q   <= '0;
         inl_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         dt_q    <= dt_d;
         sel_q   <= sel_d;
         inh_q   <= inh_d;
         inl_q   <= inl_d;
         fault_q <= fault_d;
      end
   end

   assign cur_sel = comm_sel(hall_state, dir);

   // Next state; priority fault > disable > hall error > table change
   always_comb begin
      state_d = state_q;
      dt_d    = dt_q;
      sel_d   = sel_q;
      inh_d   = '0;
      inl_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (!fsync2_q) begin
               state_d = ST_FAULT;
            end else if (enable && !hall_error) begin
               state_d = ST_DEADTIME;
               dt_d    = DT_LAST;
            end
         end
         ST_DEADTIME: begin
            if (!fsync2_q) begin
               state_d = ST_FAULT;
            end else if (!enable || hall_error) begin
               state_d = ST_IDLE;
            end else if (dt_q == '0) begin
               state_d = ST_RUN;
               sel_d   = cur_sel;
            end else begin
               dt_d = dt_q - DT_W'(1);
            end
         end
         ST_RUN: begin
            if (!fsync2_q) begin
               state_d = ST_FAULT;
            end else if (!enable || hall_error) begin
               state_d = ST_IDLE;
            end else if (cur_sel != sel_q) begin
               state_d = ST_DEADTIME;
               dt_d    = DT_LAST;
            end
         end
         ST_FAULT: begin
            if (!enable && fsync2_q) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Gates follow the next state so a fault blanks them on the same edge.
      // High and low selects are disjoint one-hot, so a leg is never shorted.
      if (state_d == ST_RUN) begin
         inh_d = cur_sel[5:3] & {3{pwm_in}};
         inl_d = cur_sel[2:0];
      end
      fault_d = (state_d == ST_FAULT);
   end

   assign inh   = inh_q;
   assign inl   = inl_q;
   assign fault = fault_q;

`ifdef BLDC_COMMUTATOR_PERIOD_EN
   logic [2:0]          hall_prev_q, hall_prev_d;
   logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                pvalid_q, pvalid_d;

   // Period measurement registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hall_prev_q <= '0;
         pcnt_q      <= '0;
         period_q    <= '0;
         pvalid_q    <= 1'b0;
      end else begin
         hall_prev_q <= hall_prev_d;
         pcnt_q      <= pcnt_d;
         period_q    <= period_d;
         pvalid_q    <= pvalid_d;
      end
   end

   // Saturating counter; capture only on valid-to-valid hall transitions
   always_comb begin
      hall_prev_d = hall_state;
      pcnt_d      = pcnt_q;
      period_d    = period_q;
      pvalid_d    = 1'b0;
      if (hall_state != hall_prev_q) begin
         pcnt_d = PERIOD_W'(1);
         if (hall_valid(hall_state) && hall_valid(hall_prev_q)) begin
            period_d = pcnt_q;
            pvalid_d = 1'b1;
         end
      end else if (pcnt_q != '1) begin
         pcnt_d = pcnt_q + PERIOD_W'(1);
      end
   end

   assign period       = period_q;
   assign period_valid = pvalid_q;
`else
   assign period       = '0;
   assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_bldc_commutator.sv
`timescale 1ns/1ps
module tb_bldc_commutator;

   localparam int unsigned PW = 24;

   logic          clk;
   logic          reset_n;
   logic [2:0]    hall;
   logic          fault_n;
   logic          enable;
   logic          dir;
   logic          pwm_in;
   logic [2:0]    inh;
   logic [2:0]    inl;
   logic [2:0]    hall_state;
   logic          hall_error;
   logic          fault;
   logic [PW-1:0] period;
   logic          period_valid;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   bldc_commutator #(
      .DEADTIME_CYCLES(16),
      .DEBOUNCE_CYCLES(32),
      .PERIOD_W       (PW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .hall        (hall),
      .fault_n     (fault_n),
      .enable      (enable),
      .dir         (dir),
      .pwm_in      (pwm_in),
      .inh         (inh),
      .inl         (inl),
      .hall_state  (hall_state),
      .hall_error  (hall_error),
      .fault       (fault),
      .period      (period),
      .period_valid(period_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // A phase leg must never have both gates on
   always @(negedge clk) begin
      if (reset_n) begin
         vectors++;
         assert ((inh & inl) === 3'b000)
         else begin
            miscompares++;
            $error("FAIL shoot_through: inh=%b inl=%b expected no overlap", inh, inl);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_exp(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      e = sb.pop_front();
      vectors++;
      assert (obs === e.val)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
   endtask

   // Wait for inl to reach a target, counting all-off cycles seen on the way
   task automatic wait_inl(input logic [2:0] tgt, input int budget,
                           output int zeros, output logic hit);
      zeros = 0;
      hit   = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (inl === tgt) hit = 1'b1;
         else if (inh === 3'b000 && inl === 3'b000) zeros++;
      end
   endtask

   task automatic wait_err(input logic tgt, input int budget, output logic hit);
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (hall_error === tgt) hit = 1'b1;
      end
   endtask

   task automatic chk_reset_vals(input string pfx);
      push_exp({pfx, "_inh"}, 32'h0);        chk(32'(inh));
      push_exp({pfx, "_inl"}, 32'h0);        chk(32'(inl));
      push_exp({pfx, "_hall_state"}, 32'h0); chk(32'(hall_state));
      push_exp({pfx, "_hall_error"}, 32'h1); chk(32'(hall_error));
      push_exp({pfx, "_fault"}, 32'h0);      chk(32'(fault));
      push_exp({pfx, "_period"}, 32'h0);     chk(32'(period));
      push_exp({pfx, "_pvalid"}, 32'h0);     chk(32'(period_valid));
   endtask

   initial begin
      int          zeros;
      logic        hit;
      int          dev;
      int          pulses;
      logic [2:0]  rot [6];

      rot[0] = 3'b100; rot[1] = 3'b110; rot[2] = 3'b010;
      rot[3] = 3'b011; rot[4] = 3'b001; rot[5] = 3'b101;

      reset_n = 1'b0;
      hall    = 3'b101;
      fault_n = 1'b1;
      enable  = 1'b1;
      dir     = 1'b0;
      pwm_in  = 1'b0;
      tick(3);
      chk_reset_vals("rst");

      // Start-up: sync + debounce + dead-time before any gate
      reset_n = 1'b1;
      wait_inl(3'b010, 200, zeros, hit);
      push_exp("startup_reached_run", 32'h1); chk(32'(hit));
      push_exp("startup_off_window", 32'h1);  chk(32'(zeros >= 50 && zeros <= 54));
      push_exp("startup_inl", 32'h2);         chk(32'(inl));
      pwm_in = 1'b1;
      push_exp("pwm_lag_inh", 32'h0);         chk(32'(inh));
      tick(1);
      push_exp("pwm_high_inh", 32'h1);        chk(32'(inh));
      pwm_in = 1'b0;
      tick(1);
      push_exp("pwm_low_inh", 32'h0);         chk(32'(inh));
      push_exp("run_hall_state", 32'h5);      chk(32'(hall_state));
      push_exp("run_hall_error", 32'h0);      chk(32'(hall_error));

      // Hall step 101 -> 100 with dead-time
      pwm_in = 1'b1;
      hall   = 3'b100;
      wait_inl(3'b100, 200, zeros, hit);
      push_exp("step_reached", 32'h1);        chk(32'(hit));
      push_exp("step_deadtime", 32'd16);      chk(32'(zeros));
      push_exp("step_inh", 32'h1);            chk(32'(inh));
      push_exp("step_inl", 32'h4);            chk(32'(inl));

      // Short glitch must be filtered
      dev  = 0;
      hall = 3'b110;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (inh !== 3'b001 || inl !== 3'b100) dev++;
      end
      hall = 3'b100;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (inh !== 3'b001 || inl !== 3'b100) dev++;
      end
      push_exp("glitch_no_change", 32'h0);    chk(32'(dev));

      // Direction reversal at hall 101
      hall = 3'b101;
      wait_inl(3'b010, 200, zeros, hit);
      push_exp("back_101_reached", 32'h1);    chk(32'(hit));
      dir = 1'b1;
      wait_inl(3'b001, 200, zeros, hit);
      push_exp("rev_reached", 32'h1);         chk(32'(hit));
      push_exp("rev_deadtime", 32'd16);       chk(32'(zeros));
      push_exp("rev_inh", 32'h2);             chk(32'(inh));
      push_exp("rev_inl", 32'h1);             chk(32'(inl));
      dir = 1'b0;
      wait_inl(3'b010, 200, zeros, hit);
      push_exp("fwd_again_reached", 32'h1);   chk(32'(hit));

      // Fault pulse, latch while enabled, clear via enable=0
      fault_n = 1'b0;
      tick(3);
      push_exp("fault_gates_off", 32'h0);     chk(32'({inh, inl}));
      push_exp("fault_set", 32'h1);           chk(32'(fault));
      fault_n = 1'b1;
      tick(20);
      push_exp("fault_held", 32'h1);          chk(32'(fault));
      push_exp("fault_held_gates", 32'h0);    chk(32'({inh, inl}));
      enable = 1'b0;
      tick(4);
      push_exp("fault_cleared", 32'h0);       chk(32'(fault));
      enable = 1'b1;
      wait_inl(3'b010, 200, zeros, hit);
      push_exp("restart_reached", 32'h1);     chk(32'(hit));

      // Rotation with 1000-cycle steps
      pulses = 0;
      for (int s = 0; s < 6; s++) begin
         hall = rot[s];
         for (int c = 0; c < 1000; c++) begin
            tick(1);
            if (period_valid === 1'b1) begin
               pulses++;
               if (pulses > 1) begin
                  push_exp("period_value", 32'd1000);
                  chk(32'(period));
               end
            end
         end
      end
`ifdef BLDC_COMMUTATOR_PERIOD_EN
      push_exp("period_pulses", 32'd6);       chk(32'(pulses));
`else
      push_exp("period_pulses", 32'd0);       chk(32'(pulses));
      push_exp("period_const", 32'd0);        chk(32'(period));
`endif

      // Invalid hall code
      hall = 3'b111;
      wait_err(1'b1, 100, hit);
      push_exp("err_reached", 32'h1);         chk(32'(hit));
      push_exp("err_hall_state", 32'h7);      chk(32'(hall_state));
      tick(2);
      push_exp("err_gates_off", 32'h0);       chk(32'({inh, inl}));

      // Reset asserted mid-dead-time
      hall = 3'b101;
      wait_err(1'b0, 100, hit);
      push_exp("valid_again", 32'h1);         chk(32'(hit));
      tick(4);
      push_exp("deadtime_gates_off", 32'h0);  chk(32'({inh, inl}));
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midrst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
